// File: rtl/bitstream_loader.sv
// bitstream_loader: packs a byte stream (MSB-first, big-endian) into 32-bit
// configuration words and writes them to the fabric's self-write port with
// programmable setup/hold pacing around a one-cycle strobe.
// Optional feature macro: BITSTREAM_LOADER_CHECKSUM_EN adds a 32-bit
// modular sum of every strobed word on the checksum output.
//
// Byte handshake: a byte is transferred on every rising CLK edge where
// byte_valid && byte_ready; byte_data must be stable while byte_valid is high,
// byte_ready is only asserted in FETCH and is withdrawn during an abort cycle.
module bitstream_loader #(
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_words,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [31:0]      SelfWriteData,
    output logic             SelfWriteStrobe,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] words_written,
    output logic [2:0]       dbg_state
`ifdef BITSTREAM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // One shared gap counter times both SETUP and HOLD.
    localparam int GAP_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int GAP_W   = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);
    localparam logic [GAP_W-1:0] SETUP_LAST = GAP_W'(SETUP_CYCLES - 1);
    localparam logic [GAP_W-1:0] HOLD_LAST  = GAP_W'(HOLD_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [GAP_W-1:0] gap_cnt;
    logic [1:0]       byte_cnt;
    logic [23:0]      shift_reg;
    logic [CNT_W-1:0] num_q;

    logic accept;
    logic word_complete;
    logic setup_end;
    logic hold_end;
    logic start_ok;
    logic strobe_ok;

    assign start_ok      = (state == S_IDLE) && start && !abort;
    assign accept        = byte_valid && byte_ready;
    assign word_complete = accept && (byte_cnt == 2'd3);
    assign setup_end     = (state == S_SETUP) && (gap_cnt == SETUP_LAST);
    assign hold_end      = (state == S_HOLD) && (gap_cnt == HOLD_LAST);
    assign strobe_ok     = (state == S_STROBE) && !abort;

    // Next-state selection; abort overrides every transition.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start_ok) next_state = (num_words == '0) ? S_DONE : S_FETCH;
            S_FETCH:  if (word_complete) next_state = S_SETUP;
            S_SETUP:  if (setup_end) next_state = S_STROBE;
            S_STROBE: next_state = S_HOLD;
            S_HOLD:   if (hold_end) next_state = (words_written == num_q) ? S_DONE : S_FETCH;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        if (abort) next_state = S_IDLE;
    end

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Gap counter: counts while staying in SETUP or HOLD, zero otherwise.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (((state == S_SETUP) || (state == S_HOLD)) && (next_state == state)) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end else begin
            gap_cnt <= '0;
        end
    end

    // Byte packing; the output word only changes on the 4th-byte edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            byte_cnt      <= 2'd0;
            shift_reg     <= 24'd0;
            SelfWriteData <= 32'd0;
        end else if (abort || (state != S_FETCH)) begin
            byte_cnt <= 2'd0;
        end else if (accept) begin
            if (byte_cnt == 2'd3) begin
                SelfWriteData <= {shift_reg, byte_data};
                byte_cnt      <= 2'd0;
            end else begin
                shift_reg <= {shift_reg[15:0], byte_data};
                byte_cnt  <= byte_cnt + 2'd1;
            end
        end
    end

    // Word bookkeeping: latch length on start, count strobes up to the length.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            num_q         <= '0;
            words_written <= '0;
        end else if (start_ok) begin
            num_q         <= num_words;
            words_written <= '0;
        end else if (strobe_ok && (words_written != num_q)) begin
            words_written <= words_written + CNT_W'(1);
        end
    end

`ifdef BITSTREAM_LOADER_CHECKSUM_EN
    // Running modular sum of strobed words, cleared on start.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)          checksum <= 32'd0;
        else if (start_ok)  checksum <= 32'd0;
        else if (strobe_ok) checksum <= checksum + SelfWriteData;
    end
`endif

    // Decoded outputs; the strobe falls with the state on an async reset.
    always_comb begin
        byte_ready      = (state == S_FETCH) && !abort;
        SelfWriteStrobe = strobe_ok;
        busy            = (state != S_IDLE);
        done            = (state == S_DONE);
        dbg_state       = state;
    end

endmodule

// File: tb/tb_bitstream_loader.sv
// Self-checking bench for bitstream_loader: table-driven control vectors,
// directed multi-cycle sequences and randomized loads against a word model.
module tb_bitstream_loader;

    localparam int SETUP_CYCLES = 2;
    localparam int HOLD_CYCLES  = 2;
    localparam int CNT_W        = 16;
    localparam int MIN_GAP      = 4 + SETUP_CYCLES + 1 + HOLD_CYCLES;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] num_words = '0;
    logic [7:0]       byte_data = 8'd0;
    logic             byte_valid = 1'b0;
    logic             byte_ready;
    logic [31:0]      SelfWriteData;
    logic             SelfWriteStrobe;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] words_written;
    logic [2:0]       dbg_state;
`ifdef BITSTREAM_LOADER_CHECKSUM_EN
    logic [31:0]      checksum;
`endif

    bitstream_loader #(
        .SETUP_CYCLES(SETUP_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .num_words      (num_words),
        .byte_data      (byte_data),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .SelfWriteData  (SelfWriteData),
        .SelfWriteStrobe(SelfWriteStrobe),
        .busy           (busy),
        .done           (done),
        .words_written  (words_written),
        .dbg_state      (dbg_state)
`ifdef BITSTREAM_LOADER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    // ---------------- clock / cycle count ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- monitor (samples on falling edge) ----------------
    logic [31:0] strobe_data_q[$];
    int          strobe_cyc_q[$];
    int          done_cyc_q[$];
    int          start_cyc = 0;
    bit          ready_seen = 1'b0;
    logic [31:0] data_hist[int];

    always @(negedge CLK) begin
        if (SelfWriteStrobe) begin
            strobe_data_q.push_back(SelfWriteData);
            strobe_cyc_q.push_back(cyc);
        end
        if (done) done_cyc_q.push_back(cyc);
        if (byte_ready) ready_seen = 1'b1;
        if (start) start_cyc = cyc;
        data_hist[cyc] = SelfWriteData;
    end

    function automatic logic [31:0] sdat(input int i);
        if (i < strobe_data_q.size()) return strobe_data_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic int scyc(input int i);
        if (i < strobe_cyc_q.size()) return strobe_cyc_q[i];
        return -1000;
    endfunction

    function automatic int dcyc(input int i);
        if (i < done_cyc_q.size()) return done_cyc_q[i];
        return -1000;
    endfunction

    function automatic bit stable_around(input int s, input logic [31:0] w);
        for (int k = s - SETUP_CYCLES; k <= s + HOLD_CYCLES; k++) begin
            if (!data_hist.exists(k)) return 1'b0;
            if (data_hist[k] !== w) return 1'b0;
        end
        return 1'b1;
    endfunction

    // ---------------- byte source driver ----------------
    logic [7:0] src_q[$];
    int         accepted = 0;
    int         src_mode = 0;   // 0: continuous, 1: every other cycle, 2: random
    bit         hs = 1'b0;
    bit         phase = 1'b0;

    always @(negedge CLK) hs = byte_valid && byte_ready;

    always @(posedge CLK) begin
        bit v;
        #1;
        if (hs && (src_q.size() > 0)) begin
            src_q.delete(0);
            accepted++;
        end
        hs = 1'b0;
        phase = ~phase;
        case (src_mode)
            0:       v = 1'b1;
            1:       v = phase;
            default: v = ($urandom_range(0, 2) != 0);
        endcase
        if ((src_q.size() > 0) && v) begin
            byte_valid = 1'b1;
            byte_data  = src_q[0];
        end else begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic clear_logs();
        strobe_data_q.delete();
        strobe_cyc_q.delete();
        done_cyc_q.delete();
        data_hist.delete();
        ready_seen = 1'b0;
        accepted   = 0;
    endtask

    task automatic push_bytes(input logic [7:0] b[$]);
        foreach (b[i]) src_q.push_back(b[i]);
    endtask

    task automatic do_start(input int n);
        num_words = CNT_W'(n);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while ((done_cyc_q.size() == 0) && (k < budget)) begin
            tick(1);
            k++;
        end
        check({name, "_done_seen"}, 32'(done_cyc_q.size() > 0), 32'd1);
        tick(2);
    endtask

    task automatic wait_accepted(input int target, input int budget, input string name);
        int k = 0;
        while ((accepted < target) && (k < budget)) begin
            tick(1);
            k++;
        end
        check({name, "_bytes_reached"}, 32'(accepted), 32'(target));
    endtask

    // Big-endian packing straight from the byte order.
    function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
        return 32'(b0) * 32'd16777216 + 32'(b1) * 32'd65536 + 32'(b2) * 32'd256 + 32'(b3);
    endfunction

    // ---------------- control vector table ----------------
    typedef struct {
        logic             start;
        logic             abort;
        logic [CNT_W-1:0] num;
        logic             exp_busy;
        logic             exp_done;
        logic             exp_ready;
        logic [CNT_W-1:0] exp_ww;
    } vec_t;

    vec_t vecs[5];

    logic [31:0] exp_q[$];

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] basic_bytes[$];
        logic [7:0] bytes[$];
        logic [31:0] sum_model;

        basic_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

        vecs[0] = '{1'b0, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[1] = '{1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[2] = '{1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[3] = '{1'b1, 1'b0, 16'd5, 1'b1, 1'b0, 1'b1, 16'd0};
        vecs[4] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd0};

        // Reset values
        reset = 1'b1;
        tick(2);
        check("rst_data",   SelfWriteData, 32'd0);
        check("rst_strobe", 32'(SelfWriteStrobe), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_ready",  32'(byte_ready), 32'd0);
        check("rst_ww",     32'(words_written), 32'd0);
`ifdef BITSTREAM_LOADER_CHECKSUM_EN
        check("rst_checksum", checksum, 32'd0);
`endif
        reset = 1'b0;
        tick(2);

        // Basic load, continuous source
        clear_logs();
        src_mode = 0;
        push_bytes(basic_bytes);
        do_start(2);
        wait_done(200, "basic");
        check("basic_strobes", 32'(strobe_data_q.size()), 32'd2);
        check("basic_word0",   sdat(0), 32'h12345678);
        check("basic_word1",   sdat(1), 32'hDEADBEEF);
        check("basic_first_strobe_lat", 32'(scyc(0) - start_cyc), 32'(1 + 4 + SETUP_CYCLES));
        check("basic_spacing", 32'(scyc(1) - scyc(0)), 32'(MIN_GAP));
        check("basic_done_after_hold", 32'(dcyc(0) - scyc(1)), 32'(HOLD_CYCLES + 1));
        check("basic_done_count", 32'(done_cyc_q.size()), 32'd1);
        check("basic_ww",      32'(words_written), 32'd2);
        check("basic_idle",    32'(busy), 32'd0);
`ifdef BITSTREAM_LOADER_CHECKSUM_EN
        check("basic_checksum", checksum, 32'h12345678 + 32'hDEADBEEF);
`endif

        // Table of single-cycle control responses from IDLE
        for (int i = 0; i < 5; i++) begin
            start     = vecs[i].start;
            abort     = vecs[i].abort;
            num_words = vecs[i].num;
            tick(1);
            start = 1'b0;
            abort = 1'b0;
            check($sformatf("vec%0d_busy", i),  32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_done", i),  32'(done), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_ready", i), 32'(byte_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_ww", i),    32'(words_written), 32'(vecs[i].exp_ww));
            abort = 1'b1;
            tick(1);
            abort = 1'b0;
            tick(2);
        end

        // Throttled source, same stream
        clear_logs();
        src_mode = 1;
        push_bytes(basic_bytes);
        do_start(2);
        wait_done(300, "thr");
        check("thr_strobes", 32'(strobe_data_q.size()), 32'd2);
        check("thr_word0",   sdat(0), 32'h12345678);
        check("thr_word1",   sdat(1), 32'hDEADBEEF);
        check("thr_stable0", 32'(stable_around(scyc(0), 32'h12345678)), 32'd1);
        check("thr_stable1", 32'(stable_around(scyc(1), 32'hDEADBEEF)), 32'd1);
        check("thr_ww",      32'(words_written), 32'd2);

        // Zero-length load: source offers bytes, none may be taken
        clear_logs();
        src_mode = 0;
        push_bytes('{8'hAA, 8'hBB, 8'hCC, 8'hDD});
        do_start(0);
        wait_done(20, "zero");
        check("zero_done_cycle", 32'(dcyc(0) - start_cyc), 32'd1);
        check("zero_ready",      32'(ready_seen), 32'd0);
        check("zero_strobes",    32'(strobe_data_q.size()), 32'd0);
        check("zero_consumed",   32'(accepted), 32'd0);
        check("zero_ww",         32'(words_written), 32'd0);
        src_q.delete();
        tick(2);

        // Abort after two bytes of word 3
        clear_logs();
        src_mode = 0;
        for (int i = 0; i < 16; i++) src_q.push_back(8'(i * 17 + 3));
        do_start(4);
        wait_accepted(10, 200, "abort");
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(20);
        check("abort_strobes", 32'(strobe_data_q.size()), 32'd2);
        check("abort_no_done", 32'(done_cyc_q.size()), 32'd0);
        check("abort_ww",      32'(words_written), 32'd2);
        check("abort_idle",    32'(busy), 32'd0);
        src_q.delete();
        tick(2);
        clear_logs();
        push_bytes('{8'hCA, 8'hFE, 8'hF0, 8'h0D});
        do_start(1);
        wait_done(100, "post_abort");
        check("post_abort_strobes", 32'(strobe_data_q.size()), 32'd1);
        check("post_abort_word",    sdat(0), 32'hCAFEF00D);
        check("post_abort_ww",      32'(words_written), 32'd1);

        // Reset during SETUP of word 2
        clear_logs();
        src_mode = 0;
        push_bytes(basic_bytes);
        do_start(2);
        wait_accepted(8, 200, "midrst");
        #1 reset = 1'b1;
        #1;
        check("midrst_data",   SelfWriteData, 32'd0);
        check("midrst_strobe", 32'(SelfWriteStrobe), 32'd0);
        check("midrst_busy",   32'(busy), 32'd0);
        check("midrst_ready",  32'(byte_ready), 32'd0);
        check("midrst_ww",     32'(words_written), 32'd0);
        tick(1);
        reset = 1'b0;
        src_q.delete();
        tick(2);
        clear_logs();
        push_bytes('{8'h01, 8'h23, 8'h45, 8'h67});
        do_start(1);
        wait_done(100, "after_rst");
        check("after_rst_strobes", 32'(strobe_data_q.size()), 32'd1);
        check("after_rst_word",    sdat(0), 32'h01234567);
        check("after_rst_ww",      32'(words_written), 32'd1);

        // Randomized loads against the word model
        for (int it = 0; it < 6; it++) begin
            int n;
            bit gaps_ok;
            clear_logs();
            exp_q.delete();
            src_mode = 2;
            n = $urandom_range(1, 4);
            sum_model = 32'd0;
            for (int w = 0; w < n; w++) begin
                logic [7:0] b0, b1, b2, b3;
                b0 = 8'($urandom); b1 = 8'($urandom);
                b2 = 8'($urandom); b3 = 8'($urandom);
                src_q.push_back(b0); src_q.push_back(b1);
                src_q.push_back(b2); src_q.push_back(b3);
                exp_q.push_back(pack(b0, b1, b2, b3));
                sum_model = sum_model + pack(b0, b1, b2, b3);
            end
            do_start(n);
            wait_done(600, $sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_strobes", it), 32'(strobe_data_q.size()), 32'(n));
            for (int w = 0; w < n; w++) begin
                check($sformatf("rnd%0d_word%0d", it, w), sdat(w), exp_q.pop_front());
            end
            gaps_ok = 1'b1;
            for (int w = 1; w < n; w++) if (scyc(w) - scyc(w - 1) < MIN_GAP) gaps_ok = 1'b0;
            check($sformatf("rnd%0d_spacing", it), 32'(gaps_ok), 32'd1);
            check($sformatf("rnd%0d_done_after_hold", it), 32'(dcyc(0) - scyc(n - 1)), 32'(HOLD_CYCLES + 1));
            check($sformatf("rnd%0d_ww", it), 32'(words_written), 32'(n));
`ifdef BITSTREAM_LOADER_CHECKSUM_EN
            check($sformatf("rnd%0d_checksum", it), checksum, sum_model);
`endif
            src_q.delete();
            tick(2);
        end

`ifdef BITSTREAM_LOADER_CHECKSUM_EN
        // Checksum wraps modulo 2^32
        clear_logs();
        src_mode = 0;
        push_bytes('{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02});
        do_start(2);
        wait_done(200, "csum");
        check("csum_wrap", checksum, 32'h00000001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
